router_sync_n: RTL and testbench

ROUTER_SYNC_N -- requirements
Module: router_sync_n

---
 rtl/router_pkg.sv | 9 +
 rtl/router_sync_n_if.sv | 31 +++
 rtl/router_sync_timeout.sv | 38 +++
 rtl/router_sync_n.sv | 64 ++++++
 tb/tb_router_sync_n.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared defaults for the sync router and its per-port stall timers.
// Latency: n/a (constants only).
// Backpressure: n/a.
package router_pkg;
    localparam int N_PORTS_DEF = 3;
    localparam int AW_DEF      = 2;
    localparam int TIMEOUT_DEF = 30;
    localparam int CNT_W       = 8;
endpackage

// File: rtl/router_sync_n_if.sv
// Router sync bundle: header capture, FIFO status, write/valid/soft-reset fan-out.
// Latency: n/a (wires only).
// Backpressure: full/rd_en carried as plain status; no handshake of its own.
interface router_sync_n_if
    import router_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int AW      = AW_DEF
);
    logic               detect_add;
    logic [AW-1:0]      d_in;
    logic               wr_en_reg;
    logic [N_PORTS-1:0] full;
    logic [N_PORTS-1:0] empty;
    logic [N_PORTS-1:0] rd_en;
    logic [N_PORTS-1:0] wr_en;
    logic               fifo_full;
    logic [N_PORTS-1:0] vld_out;
    logic [N_PORTS-1:0] soft_rst;
    logic               addr_err;

    modport master (
        output detect_add, d_in, wr_en_reg, full, empty, rd_en,
        input  wr_en, fifo_full, vld_out, soft_rst, addr_err
    );

    modport slave (
        input  detect_add, d_in, wr_en_reg, full, empty, rd_en,
        output wr_en, fifo_full, vld_out, soft_rst, addr_err
    );
endinterface

// File: rtl/router_sync_timeout.sv
// Per-port stall timer: pulses soft_rst after TIMEOUT consecutive unread-valid cycles.
// Latency: pulse registered on the edge closing the TIMEOUT-th stall cycle.
// Backpressure: any read or loss of valid clears the count.
module router_sync_timeout
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CW      = CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic rd_en,
    output logic soft_rst
);
    logic [CW-1:0] cnt;
    logic          stall;

    assign stall = vld && !rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            soft_rst <= 1'b0;
        end else if (stall) begin
            if (cnt == CW'(TIMEOUT - 1)) begin
                cnt      <= '0;
                soft_rst <= 1'b1;
            end else begin
                cnt      <= cnt + CW'(1);
                soft_rst <= 1'b0;
            end
        end else begin
            cnt      <= '0;
            soft_rst <= 1'b0;
        end
    end
endmodule

// File: rtl/router_sync_n.sv
// Router synchroniser: latches destination, steers write enable/full, per-port stall timers.
// Latency: address used one cycle after detect_add; wr_en/fifo_full/vld_out combinational.
// Backpressure: fifo_full reflects the selected FIFO; forced high on an illegal address.
module router_sync_n
    import router_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int AW      = AW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    router_sync_n_if.slave  bus
);
    logic [AW-1:0]      addr;
    logic               addr_err;
    logic [N_PORTS-1:0] wr_en_dat;
    logic               fifo_full_dat;
    logic [N_PORTS-1:0] vld_dat;
    logic [N_PORTS-1:0] soft_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
        end else if (bus.detect_add) begin
            addr <= bus.d_in;
        end
    end

    assign addr_err = ({1'b0, addr} >= (AW + 1)'(N_PORTS));

    // An out-of-range address matches no port, leaving wr_en idle and full asserted.
    always_comb begin
        wr_en_dat     = '0;
        fifo_full_dat = 1'b1;
        for (int i = 0; i < N_PORTS; i++) begin
            if (addr == AW'(i)) begin
                wr_en_dat[i]  = bus.wr_en_reg;
                fifo_full_dat = bus.full[i];
            end
        end
    end

    assign vld_dat = ~bus.empty;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_timeout
        router_sync_timeout #(
            .TIMEOUT (TIMEOUT),
            .CW      (CNT_W)
        ) u_timeout (
            .clk      (clk),
            .rst      (rst),
            .vld      (vld_dat[i]),
            .rd_en    (bus.rd_en[i]),
            .soft_rst (soft_dat[i])
        );
    end

    assign bus.wr_en     = wr_en_dat;
    assign bus.fifo_full = fifo_full_dat;
    assign bus.vld_out   = vld_dat;
    assign bus.soft_rst  = soft_dat;
    assign bus.addr_err  = addr_err;
endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n: vector table for steering, hand sequences for stall timers.
module tb_router_sync_n;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    router_sync_n_if #(.N_PORTS(3), .AW(2)) bus ();

    router_sync_n #(.N_PORTS(3), .AW(2), .TIMEOUT(30)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       da;
        logic [1:0] d_in;
        logic       wer;
        logic [2:0] full;
        logic [2:0] empty;
        logic [2:0] rd;
        logic [2:0] e_wr;
        logic       e_ff;
        logic [2:0] e_vld;
        logic       e_err;
    } vec_t;

    vec_t vt [11];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_soft_rst", {29'd0, bus.soft_rst}, 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.detect_add = 1'b0;
        bus.d_in       = 2'd0;
        bus.wr_en_reg  = 1'b0;
        bus.full       = 3'b000;
        bus.empty      = 3'b111;
        bus.rd_en      = 3'b000;

        //         rst  da   d_in  wer   full    empty   rd      e_wr    e_ff  e_vld   e_err
        vt[0]  = '{1'b1,1'b1,2'd2,1'b1,3'b010,3'b111,3'b000,3'b001,1'b0,3'b000,1'b0};
        vt[1]  = '{1'b1,1'b1,2'd2,1'b1,3'b010,3'b111,3'b000,3'b001,1'b0,3'b000,1'b0};
        vt[2]  = '{1'b0,1'b1,2'd1,1'b1,3'b010,3'b111,3'b000,3'b010,1'b1,3'b000,1'b0};
        vt[3]  = '{1'b0,1'b0,2'd3,1'b1,3'b010,3'b111,3'b000,3'b010,1'b1,3'b000,1'b0};
        vt[4]  = '{1'b0,1'b1,2'd3,1'b1,3'b000,3'b111,3'b000,3'b000,1'b1,3'b000,1'b1};
        vt[5]  = '{1'b0,1'b0,2'd0,1'b1,3'b000,3'b111,3'b000,3'b000,1'b1,3'b000,1'b1};
        vt[6]  = '{1'b0,1'b1,2'd2,1'b1,3'b100,3'b111,3'b000,3'b100,1'b1,3'b000,1'b0};
        vt[7]  = '{1'b0,1'b0,2'd0,1'b0,3'b011,3'b111,3'b000,3'b000,1'b0,3'b000,1'b0};
        vt[8]  = '{1'b0,1'b1,2'd0,1'b1,3'b001,3'b010,3'b000,3'b001,1'b1,3'b101,1'b0};
        vt[9]  = '{1'b1,1'b1,2'd2,1'b1,3'b000,3'b000,3'b000,3'b001,1'b0,3'b111,1'b0};
        vt[10] = '{1'b0,1'b0,2'd0,1'b1,3'b110,3'b101,3'b000,3'b001,1'b0,3'b010,1'b0};

        for (int v = 0; v < 11; v++) begin
            rst            = vt[v].rst;
            bus.detect_add = vt[v].da;
            bus.d_in       = vt[v].d_in;
            bus.wr_en_reg  = vt[v].wer;
            bus.full       = vt[v].full;
            bus.empty      = vt[v].empty;
            bus.rd_en      = vt[v].rd;
            tick();
            chk($sformatf("v%0d_wr_en", v),     {29'd0, bus.wr_en},     {29'd0, vt[v].e_wr});
            chk($sformatf("v%0d_fifo_full", v), {31'd0, bus.fifo_full}, {31'd0, vt[v].e_ff});
            chk($sformatf("v%0d_vld_out", v),   {29'd0, bus.vld_out},   {29'd0, vt[v].e_vld});
            chk($sformatf("v%0d_addr_err", v),  {31'd0, bus.addr_err},  {31'd0, vt[v].e_err});
            chk($sformatf("v%0d_soft_rst", v),  {29'd0, bus.soft_rst},  32'd0);
        end
        bus.detect_add = 1'b0;
        bus.wr_en_reg  = 1'b0;

        // Port 0 stalled continuously: pulses after edges 30 and 60 only.
        bus.empty = 3'b111;
        bus.rd_en = 3'b000;
        do_reset();
        bus.empty = 3'b110;
        for (int k = 1; k <= 61; k++) begin
            tick();
            chk($sformatf("p0_stall_e%0d", k), {29'd0, bus.soft_rst},
                (k == 30 || k == 60) ? 32'd1 : 32'd0);
        end

        // Port 1: 29 stalls, one read, 29 stalls -> silent; the 30th restarted stall pulses.
        bus.empty = 3'b111;
        do_reset();
        bus.empty = 3'b101;
        for (int k = 1; k <= 60; k++) begin
            bus.rd_en = (k == 30) ? 3'b010 : 3'b000;
            tick();
            chk($sformatf("p1_broken_e%0d", k), {29'd0, bus.soft_rst},
                (k == 60) ? 32'd2 : 32'd0);
        end
        bus.rd_en = 3'b000;

        // Ports 0 and 2 stalled together pulse together.
        bus.empty = 3'b111;
        do_reset();
        bus.empty = 3'b010;
        for (int k = 1; k <= 31; k++) begin
            tick();
            chk($sformatf("p02_stall_e%0d", k), {29'd0, bus.soft_rst},
                (k == 30) ? 32'd5 : 32'd0);
        end

        // Reset mid-stall at count 20 discards progress; full 30 cycles needed afterwards.
        bus.empty = 3'b111;
        do_reset();
        bus.empty = 3'b110;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("rst_pre_e%0d", k), {29'd0, bus.soft_rst}, 32'd0);
        end
        do_reset();
        for (int k = 1; k <= 31; k++) begin
            tick();
            chk($sformatf("rst_post_e%0d", k), {29'd0, bus.soft_rst},
                (k == 30) ? 32'd1 : 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
